exe_unit_sequencer: RTL and testbench
=====================================

# exe_unit_sequencer

Initiator-side front end for `exe_unit_w1`. It accepts operation requests over a valid/ready handshake and drives `oper`/`argA`/`argB` into the execution unit. It waits out the unit's pipeline latency, captures `result`/`status`, and returns them over a second valid/ready handshake. It replaces free-running stimulus toward the execution unit with a flow-controlled, one-operation-in-flight command port, and keeps a saturating count of non-OK statuses.

## Interface
- `m`, default 8: operand/result width; must match `exe_unit_w1` `m`.
- `n`, default 2: opcode width; must match `exe_unit_w1` `n`.
- `LAT`, default 1: clock edges from operands presented to execution unit until its `o_result`/`o_status` are valid; legal range 0..15.

- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_rsn`  in  1  reset, synchronous, active-low.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  sequencer can accept a request.
- `i_req_oper`  in  n  opcode.
- `i_req_argA`  in  m  operand A, signed.
- `i_req_argB`  in  m  operand B, signed.
- `o_exe_oper`  out  n  to `exe_unit_w1.i_oper`.
- `o_exe_argA`  out  m  to `exe_unit_w1.i_argA`.
- `o_exe_argB`  out  m  to `exe_unit_w1.i_argB`.
- `i_exe_result`  in  m  from `exe_unit_w1.o_result`.
- `i_exe_status`  in  2  from `exe_unit_w1.o_status`.
- `o_rsp_valid`  out  1  response present.
- `i_rsp_ready`  in  1  consumer takes response.
- `o_rsp_result`  out  m  captured result.
- `o_rsp_status`  out  2  captured status.
- `o_err_cnt`  out  8  saturating count of captured statuses other than `STATUS_OK`.
- `o_busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** `o_req_ready=1`. When `i_req_valid` is high at an edge, the sequencer:
  - registers the opcode and operands into `o_exe_*`,
  - loads the wait counter with `LAT`,
  - moves to WAIT.
- **WAIT:** at each edge, if the counter is 0, capture `i_exe_result`/`i_exe_status` into the `o_rsp_*` registers and move to RESP. Otherwise decrement the counter.
- **RESP:** `o_rsp_valid=1`. `o_rsp_*` are held stable. On an edge with `i_rsp_ready=1`, move to IDLE.
- `o_req_ready=0` in WAIT and RESP. Requests presented there are ignored, not queued.
- `o_exe_*` hold their last value until the next acceptance, including through RESP and IDLE.
- `o_err_cnt` increments by 1 on the capture edge when the status differs from `STATUS_OK` (2'b00). It saturates at 255 and never wraps.
- Operands pass through unmodified. The sequencer does no arithmetic and no sign handling.

## Timing
- Reset (`i_rsn=0` at an edge) forces:
  - state IDLE,
  - `o_exe_oper`, `o_exe_argA`, `o_exe_argB`, `o_rsp_result`, `o_rsp_status`, `o_err_cnt` all 0,
  - `o_rsp_valid=0`, `o_busy=0`.
- `o_req_ready` is 1 in the first cycle after reset.
- If a request is accepted at edge k, `o_exe_*` are valid after edge k.
- `o_rsp_valid` rises after edge k+LAT+1. Examples: LAT=0 gives k+1; LAT=1 gives k+2.
- The earliest next acceptance is the edge after the response handshake edge. Minimum issue interval is LAT+3 cycles with `i_rsp_ready` tied high.
- Reset mid-operation (WAIT or RESP): the in-flight operation is discarded and no response is produced. Reset takes priority over every handshake on the same edge.
- Request and response handshakes cannot both occur on the same edge, because `o_req_ready` and `o_rsp_valid` are mutually exclusive.
- `o_err_cnt` is cleared only by reset.

## Structure
- Shared package `exe_pkg` holds:
  - `STATUS_OK = 2'b00`,
  - the sequencer state enum typedef `seq_state_t` (IDLE, WAIT, RESP),
  - the width of `o_err_cnt` (`ERR_CNT_W = 8`).
- One sub-module, `sat_counter`:
  - parameterised width,
  - synchronous active-low clear,
  - increment enable,
  - holds at all-ones.
- `exe_unit_sequencer` instantiates `sat_counter` for `o_err_cnt`.
- The top-level integration instantiates `exe_unit_sequencer` and `exe_unit_w1` side by side, with matching `m`, `n` and `LAT`.

## Test plan
- **Reset:** `i_rsn=0` for 2 edges with `i_req_valid=1`. All outputs are 0, `o_busy=0`, and `o_req_ready=1` after release.
- **Single op, LAT=1:** request oper=2'b11, A=8'sd5, B=-8'sd2 accepted at edge k; stub returns result 8'h03, status 2'b00.
  - `o_exe_*` = 2'b11 / 8'h05 / 8'hFE after k.
  - `o_rsp_valid` rises after k+2 with result 8'h03.
  - `o_err_cnt=0`.
- **Backpressure:** `i_rsp_ready=0` for 5 cycles in RESP while `i_req_valid=1` with new operands.
  - `o_rsp_*` are held, `o_req_ready=0`, and `o_exe_*` are unchanged.
  - The single ready edge returns the FSM to IDLE.
- **Error count:** stub returns status 2'b10 for 3 ops, giving `o_err_cnt=3`. Then 300 more error ops, giving `o_err_cnt=255`.
- **Reset mid-WAIT (LAT=3):** `i_rsn=0` at edge k+2. No `o_rsp_valid` pulse, state IDLE, `o_err_cnt=0`.
- **Latency sweep, LAT=0 and LAT=3:** `o_rsp_valid` rises after edge k+1 and k+4 respectively, and the captured value equals the stub output at the capture edge.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execution-unit sequencer slice.
package exe_pkg;

  // Status code the execution unit reports for a clean result.
  localparam logic [1:0] STATUS_OK = 2'b00;

  // Width of the saturating error counter exported by the sequencer.
  localparam int unsigned ERR_CNT_W = 8;

  // Width of the latency wait counter; holds LAT values 0..15.
  localparam int unsigned LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } seq_state_t;

  // True when a captured status should count as an error.
  function automatic logic is_err_status(input logic [1:0] st);
    return st != STATUS_OK;
  endfunction

endpackage

// File: rtl/exe_unit_sequencer_if.sv
// Request/response handshake bundle between a command source and the sequencer.
interface exe_unit_sequencer_if #(
  parameter int unsigned m = 8,
  parameter int unsigned n = 2
);

  logic         i_req_valid;
  logic         o_req_ready;
  logic [n-1:0] i_req_oper;
  logic [m-1:0] i_req_argA;
  logic [m-1:0] i_req_argB;

  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic [m-1:0] o_rsp_result;
  logic [1:0]   o_rsp_status;

  // Command source side.
  modport master (
    output i_req_valid, i_req_oper, i_req_argA, i_req_argB, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_status
  );

  // Sequencer side.
  modport slave (
    input  i_req_valid, i_req_oper, i_req_argA, i_req_argB, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_status
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: advance only while below the saturation value.
  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/exe_unit_sequencer.sv
// One-operation-in-flight front end for exe_unit_w1: accepts a request,
// waits out the unit latency, captures result/status, returns a response.
module exe_unit_sequencer
  import exe_pkg::*;
#(
  parameter int unsigned m   = 8,
  parameter int unsigned n   = 2,
  parameter int unsigned LAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rsn,
  exe_unit_sequencer_if.slave  cmd,
  output logic [n-1:0]         o_exe_oper,
  output logic [m-1:0]         o_exe_argA,
  output logic [m-1:0]         o_exe_argB,
  input  logic [m-1:0]         i_exe_result,
  input  logic [1:0]           i_exe_status,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic                 o_busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_V = LAT_CNT_W'(LAT);

  seq_state_t           state_q;
  logic [LAT_CNT_W-1:0] wait_q;
  logic [n-1:0]         exe_oper_q;
  logic [m-1:0]         exe_argA_q;
  logic [m-1:0]         exe_argB_q;
  logic [m-1:0]         rsp_result_q;
  logic [1:0]           rsp_status_q;
  logic                 rsp_valid_q;
  logic                 req_ready_q;
  logic                 busy_q;
  logic                 capture;
  logic                 err_inc;

  // Capture edge: last WAIT cycle, when the unit output is valid.
  assign capture = (state_q == WAIT) && (wait_q == '0);
  assign err_inc = capture && is_err_status(i_exe_status);

  // Sequencer FSM; every handshake output is registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rsn) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      exe_oper_q   <= '0;
      exe_argA_q   <= '0;
      exe_argB_q   <= '0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
      rsp_valid_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd.i_req_valid) begin
            exe_oper_q  <= cmd.i_req_oper;
            exe_argA_q  <= cmd.i_req_argA;
            exe_argB_q  <= cmd.i_req_argB;
            wait_q      <= LAT_V;
            state_q     <= WAIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_q == '0) begin
            rsp_result_q <= i_exe_result;
            rsp_status_q <= i_exe_status;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            wait_q <= wait_q - LAT_CNT_W'(1);
          end
        end
        RESP: begin
          if (cmd.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .i_clk   (i_clk),
    .i_clr_n (i_rsn),
    .i_inc   (err_inc),
    .o_cnt   (o_err_cnt)
  );

  assign cmd.o_req_ready  = req_ready_q;
  assign cmd.o_rsp_valid  = rsp_valid_q;
  assign cmd.o_rsp_result = rsp_result_q;
  assign cmd.o_rsp_status = rsp_status_q;
  assign o_exe_oper       = exe_oper_q;
  assign o_exe_argA       = exe_argA_q;
  assign o_exe_argB       = exe_argB_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_exe_unit_sequencer.sv
// Scoreboard bench: three sequencers (LAT=1, 0, 3) each with a delay-line stub.
module tb_exe_unit_sequencer;
  import exe_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic [1:0] st;
    int         k;
  } exp_t;

  logic clk = 1'b0;
  logic rsn;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       req_valid  [3];
  logic [1:0] req_oper   [3];
  logic [7:0] req_a      [3];
  logic [7:0] req_b      [3];
  logic       rsp_ready  [3];
  logic [1:0] stub_status[3];
  logic       req_ready  [3];
  logic       rsp_valid  [3];
  logic [7:0] rsp_result [3];
  logic [1:0] rsp_status [3];
  logic [1:0] exe_oper   [3];
  logic [7:0] exe_a      [3];
  logic [7:0] exe_b      [3];
  logic [7:0] exe_res    [3];
  logic [1:0] exe_st     [3];
  logic [7:0] err_cnt    [3];
  logic       busy       [3];

  exp_t sbq[3][$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int LAT_G = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    exe_unit_sequencer_if #(.m(8), .n(2)) bus ();

    assign bus.i_req_valid = req_valid[g];
    assign bus.i_req_oper  = req_oper[g];
    assign bus.i_req_argA  = req_a[g];
    assign bus.i_req_argB  = req_b[g];
    assign bus.i_rsp_ready = rsp_ready[g];
    assign req_ready[g]    = bus.o_req_ready;
    assign rsp_valid[g]    = bus.o_rsp_valid;
    assign rsp_result[g]   = bus.o_rsp_result;
    assign rsp_status[g]   = bus.o_rsp_status;

    exe_unit_sequencer #(.m(8), .n(2), .LAT(LAT_G)) dut (
      .i_clk        (clk),
      .i_rsn        (rsn),
      .cmd          (bus),
      .o_exe_oper   (exe_oper[g]),
      .o_exe_argA   (exe_a[g]),
      .o_exe_argB   (exe_b[g]),
      .i_exe_result (exe_res[g]),
      .i_exe_status (exe_st[g]),
      .o_err_cnt    (err_cnt[g]),
      .o_busy       (busy[g])
    );

    // Stub execution unit: result = A + B, status from the bench, LAT_G-edge pipeline.
    logic [9:0] comb;
    logic [9:0] dl[4];
    assign comb = {exe_a[g] + exe_b[g], stub_status[g]};
    always @(posedge clk) begin
      dl[0] <= comb;
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
    end
    assign {exe_res[g], exe_st[g]} = (LAT_G == 0) ? comb : dl[(LAT_G == 0) ? 0 : LAT_G - 1];

    // Monitor: pop on response rise, then require stability while held.
    logic       prev_v = 1'b0;
    logic [7:0] held_res;
    logic [1:0] held_st;
    always @(negedge clk) begin
      exp_t e;
      if (rsp_valid[g] && !prev_v) begin
        if (sbq[g].size() == 0) begin
          chk($sformatf("unexpected_rsp_d%0d", g), 1, 0);
        end else begin
          e = sbq[g].pop_front();
          chk($sformatf("rsp_result_d%0d", g), int'(rsp_result[g]), int'(e.res));
          chk($sformatf("rsp_status_d%0d", g), int'(rsp_status[g]), int'(e.st));
          chk($sformatf("rsp_latency_d%0d", g), cyc, e.k + LAT_G + 1);
        end
        held_res = rsp_result[g];
        held_st  = rsp_status[g];
      end else if (rsp_valid[g]) begin
        chk($sformatf("rsp_hold_res_d%0d", g), int'(rsp_result[g]), int'(held_res));
        chk($sformatf("rsp_hold_st_d%0d", g), int'(rsp_status[g]), int'(held_st));
        chk($sformatf("ready_in_resp_d%0d", g), int'(req_ready[g]), 0);
      end
      prev_v = rsp_valid[g];
    end
  end

  // Present a request at a negedge, wait for acceptance, check o_exe_* after edge k.
  task automatic issue(input int d, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] st, input bit push);
    int         nw;
    logic [7:0] r;
    exp_t       e;
    nw = 0;
    stub_status[d] = st;
    req_oper[d] = op;
    req_a[d] = a;
    req_b[d] = b;
    req_valid[d] = 1'b1;
    while (!req_ready[d] && nw < 50) begin
      @(negedge clk);
      nw++;
    end
    if (nw >= 50) begin
      chk("req_accept_timeout", 0, 1);
      req_valid[d] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    r = a + b;
    e.res = r;
    e.st  = st;
    e.k   = cyc;
    if (push) sbq[d].push_back(e);
    chk("exe_oper", int'(exe_oper[d]), int'(op));
    chk("exe_argA", int'(exe_a[d]), int'(a));
    chk("exe_argB", int'(exe_b[d]), int'(b));
    chk("busy_after_accept", int'(busy[d]), 1);
  endtask

  task automatic wait_idle(input int d);
    int nw;
    nw = 0;
    while ((busy[d] || rsp_valid[d]) && nw < 60) begin
      @(negedge clk);
      nw++;
    end
    if (nw >= 60) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b1;
      req_oper[d] = 2'b11;
      req_a[d] = 8'h5A;
      req_b[d] = 8'hA5;
      rsp_ready[d] = 1'b1;
      stub_status[d] = 2'b10;
    end
    rsn = 1'b0;

    // Reset with requests pending.
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_exe_oper", int'(exe_oper[d]), 0);
      chk("rst_exe_argA", int'(exe_a[d]), 0);
      chk("rst_exe_argB", int'(exe_b[d]), 0);
      chk("rst_rsp_result", int'(rsp_result[d]), 0);
      chk("rst_rsp_status", int'(rsp_status[d]), 0);
      chk("rst_rsp_valid", int'(rsp_valid[d]), 0);
      chk("rst_err_cnt", int'(err_cnt[d]), 0);
      chk("rst_busy", int'(busy[d]), 0);
      req_valid[d] = 1'b0;
      stub_status[d] = 2'b00;
    end
    rsn = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("post_rst_req_ready", int'(req_ready[d]), 1);
      chk("post_rst_busy", int'(busy[d]), 0);
    end

    // Single op, LAT=1: 5 + (-2) = 3.
    issue(0, 2'b11, 8'h05, 8'hFE, 2'b00, 1'b1);
    wait_idle(0);
    chk("single_err_cnt", int'(err_cnt[0]), 0);

    // Backpressure: response held, new request ignored.
    rsp_ready[0] = 1'b0;
    issue(0, 2'b01, 8'h7F, 8'h01, 2'b00, 1'b1);
    for (int i = 0; i < 20 && !rsp_valid[0]; i++) @(negedge clk);
    chk("bp_rsp_seen", int'(rsp_valid[0]), 1);
    req_valid[0] = 1'b1;
    req_oper[0] = 2'b10;
    req_a[0] = 8'h11;
    req_b[0] = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", int'(rsp_valid[0]), 1);
      chk("bp_req_ready", int'(req_ready[0]), 0);
      chk("bp_exe_oper", int'(exe_oper[0]), 1);
      chk("bp_exe_argA", int'(exe_a[0]), 8'h7F);
      chk("bp_exe_argB", int'(exe_b[0]), 8'h01);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(rsp_valid[0]), 0);
    chk("bp_release_busy", int'(busy[0]), 0);
    chk("bp_release_ready", int'(req_ready[0]), 1);
    chk("bp_exe_hold_idle", int'(exe_a[0]), 8'h7F);

    // Error counting and saturation.
    for (int i = 0; i < 3; i++) begin
      issue(0, 2'b00, 8'(i), 8'h01, 2'b10, 1'b1);
      wait_idle(0);
    end
    chk("err_cnt_3", int'(err_cnt[0]), 3);
    for (int i = 0; i < 300; i++) begin
      issue(0, 2'b10, 8'(i), 8'h03, (i % 3 == 0) ? 2'b01 : ((i % 3 == 1) ? 2'b11 : 2'b10), 1'b1);
      wait_idle(0);
    end
    chk("err_cnt_sat", int'(err_cnt[0]), 255);
    issue(0, 2'b01, 8'h40, 8'h02, 2'b00, 1'b1);
    wait_idle(0);
    chk("err_cnt_sat_ok", int'(err_cnt[0]), 255);

    // Latency sweep LAT=0 and LAT=3.
    issue(1, 2'b10, 8'h10, 8'h20, 2'b00, 1'b1);
    wait_idle(1);
    issue(1, 2'b01, 8'hF0, 8'h0E, 2'b01, 1'b1);
    wait_idle(1);
    chk("lat0_err_cnt", int'(err_cnt[1]), 1);
    issue(2, 2'b01, 8'h80, 8'h81, 2'b11, 1'b1);
    wait_idle(2);
    issue(2, 2'b11, 8'hC3, 8'h3C, 2'b00, 1'b1);
    wait_idle(2);
    chk("lat3_err_cnt", int'(err_cnt[2]), 1);

    // Reset two edges into WAIT on LAT=3: operation dropped, counter cleared.
    issue(2, 2'b11, 8'h33, 8'h44, 2'b10, 1'b0);
    @(negedge clk);
    rsn = 1'b0;
    @(negedge clk);
    rsn = 1'b1;
    chk("midrst_busy", int'(busy[2]), 0);
    chk("midrst_err_cnt", int'(err_cnt[2]), 0);
    chk("midrst_req_ready", int'(req_ready[2]), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", int'(rsp_valid[2]), 0);
    end
    chk("midrst_exe_cleared", int'(exe_a[2]), 0);

    for (int d = 0; d < 3; d++) chk("sb_empty", sbq[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
